// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared timing types, the default 640x480@60 timing set and the helpers
//   that derive an axis total (visible + front porch + sync + back porch).
//   Imported by vga_axis_cnt and vga_sync_timing.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // One raster axis described by its four regions, in ticks (h) or lines (v).
  typedef struct packed {
    int visible;
    int fp;
    int sync;
    int bp;
  } vga_timing_t;

  // Default 640x480@60 timing (25 MHz pixel tick).
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  function automatic vga_timing_t make_timing(input int visible, input int fp,
                                              input int sync, input int bp);
    vga_timing_t t;
    t.visible = visible;
    t.fp      = fp;
    t.sync    = sync;
    t.bp      = bp;
    return t;
  endfunction

  // H_TOTAL and V_TOTAL are both derived through this one rule.
  function automatic int axis_total(input vga_timing_t t);
    return t.visible + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// -----------------------------------------------------------------------------
// vga_axis_cnt
//   One raster axis: a wrap counter with enable plus region decode. The sync
//   and active flags are registered from the value the counter is about to
//   load, so they are coherent with pos in the same cycle.
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   en           advance one position on this clk edge
//   pos          current position, resets to TOTAL-1
//   wrap         pos is at TOTAL-1 (next enabled edge loads 0)
//   active_nxt   visible-region flag the next edge will hold (current if !en)
//   sync         sync output at level POL while inside the sync region
// -----------------------------------------------------------------------------
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FP      = DEF_H_FP,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BP      = DEF_H_BP,
  parameter bit POL     = 1'b0,
  localparam int TOTAL  = axis_total(make_timing(VISIBLE, FP, SYNC, BP)),
  localparam int W      = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] pos,
  output logic         wrap,
  output logic         active_nxt,
  output logic         sync
);

  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END  = W'(VISIBLE);
  localparam logic [W-1:0] SYNC_BEG = W'(VISIBLE + FP);
  localparam logic [W-1:0] SYNC_END = W'(VISIBLE + FP + SYNC);

  logic [W-1:0] nxt;
  logic         active;

  assign wrap       = (pos == LAST);
  assign nxt        = wrap ? '0 : pos + 1'b1;
  assign active_nxt = en ? (nxt < VIS_END) : active;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; reset is checked first so it wins over a coincident en.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos    <= LAST;
      active <= 1'b0;
      sync   <= ~POL;
    end else if (en) begin
      pos    <= nxt;
      active <= (nxt < VIS_END);
      sync   <= ((nxt >= SYNC_BEG) && (nxt < SYNC_END)) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_sync_timing.sv
// -----------------------------------------------------------------------------
// vga_sync_timing
//   Turns the one-clk pixel tick into VGA raster timing: x/y counters, hsync,
//   vsync, display enable and line/frame start pulses. Everything changes only
//   on a clk edge with pclk=1, except the start pulses, which drop after one clk.
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   pclk           pixel tick enable (one clk wide, any spacing)
//   hsync, vsync   sync outputs, active level HSYNC_POL / VSYNC_POL
//   de             (x,y) inside the visible area
//   x, y           raster position
//   line_start     one-clk pulse on the edge that loads x=0
//   frame_start    one-clk pulse on the edge that loads (0,0)
//   frame_cnt      completed-frame count, present only with VGA_FRAME_CNT_EN
// Configuration macro: VGA_FRAME_CNT_EN
// -----------------------------------------------------------------------------
module vga_sync_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int H_TOTAL  = axis_total(make_timing(H_VISIBLE, H_FP, H_SYNC, H_BP)),
  localparam int V_TOTAL  = axis_total(make_timing(V_VISIBLE, V_FP, V_SYNC, V_BP)),
  localparam int H_W      = $clog2(H_TOTAL),
  localparam int V_W      = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pclk,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           line_start,
  output logic           frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]    frame_cnt
`endif
);

  logic h_wrap, v_wrap, v_en;
  logic h_active_nxt, v_active_nxt;

  // The vertical axis steps only on the tick that wraps x.
  assign v_en = pclk & h_wrap;

  vga_axis_cnt #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .POL     (HSYNC_POL)
  ) u_h_cnt (
    .clk        (clk),
    .reset      (reset),
    .en         (pclk),
    .pos        (x),
    .wrap       (h_wrap),
    .active_nxt (h_active_nxt),
    .sync       (hsync)
  );

  vga_axis_cnt #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .POL     (VSYNC_POL)
  ) u_v_cnt (
    .clk        (clk),
    .reset      (reset),
    .en         (v_en),
    .pos        (y),
    .wrap       (v_wrap),
    .active_nxt (v_active_nxt),
    .sync       (vsync)
  );

  // de is registered from both axes' next-state flags so it never glitches
  // when x and y change on the same edge. The pulses clear on any non-tick edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      de          <= h_active_nxt & v_active_nxt;
      line_start  <= pclk & h_wrap;
      frame_start <= v_en & v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (v_en && v_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_timing
//   Two instances share clk/reset/pclk: one with a tiny raster (23x11, hsync
//   active-high) so full frames fit in a short run, one with the default
//   640x480 timing. A linear-position model (p = y*H_TOTAL + x) predicts every
//   output after each edge; per-frame and per-line totals are also checked.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync_timing;

  localparam int SH_V = 16, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_V = 6,  SV_F = 1, SV_S = 2, SV_B = 2;
  localparam int SHT  = SH_V + SH_F + SH_S + SH_B;   // 23
  localparam int SVT  = SV_V + SV_F + SV_S + SV_B;   // 11

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pclk = 1'b0;
  always #5 clk = ~clk;

  logic       hs_s, vs_s, de_s, ls_s, fs_s;
  logic [4:0] x_s;
  logic [3:0] y_s;
  logic       hs_d, vs_d, de_d, ls_d, fs_d;
  logic [9:0] x_d;
  logic [9:0] y_d;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_s, fc_d;
`endif

  vga_sync_timing #(
    .H_VISIBLE (SH_V), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
    .V_VISIBLE (SV_V), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b0)
  ) dut_s (
    .clk (clk), .reset (reset), .pclk (pclk),
    .hsync (hs_s), .vsync (vs_s), .de (de_s), .x (x_s), .y (y_s),
    .line_start (ls_s), .frame_start (fs_s)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt (fc_s)
`endif
  );

  vga_sync_timing dut_d (
    .clk (clk), .reset (reset), .pclk (pclk),
    .hsync (hs_d), .vsync (vs_d), .de (de_d), .x (x_d), .y (y_d),
    .line_start (ls_d), .frame_start (fs_d)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt (fc_d)
`endif
  );

  // ---------------- reference model (index 0 = small, 1 = default) ----------
  int m_ht[2], m_hv[2], m_hs0[2], m_hs1[2];
  int m_vt[2], m_vv[2], m_vs0[2], m_vs1[2];
  bit m_hpol[2], m_vpol[2];
  int m_p[2];
  bit m_ls[2], m_fs[2];
  int m_fc[2];

  int checks = 0;
  int failures = 0;

  // running totals between frame starts (small) and line starts (default)
  bit f_seen = 1'b0;
  int f_ticks = 0, f_de = 0, f_vs = 0;
  bit l_seen = 1'b0;
  int l_ticks = 0, l_de = 0, l_hs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_axis(input int i, input int hv, input int hf, input int hs, input int hb,
                          input int vv, input int vf, input int vs, input int vb,
                          input bit hpol, input bit vpol);
    m_hv[i] = hv; m_hs0[i] = hv + hf; m_hs1[i] = hv + hf + hs; m_ht[i] = hv + hf + hs + hb;
    m_vv[i] = vv; m_vs0[i] = vv + vf; m_vs1[i] = vv + vf + vs; m_vt[i] = vv + vf + vs + vb;
    m_hpol[i] = hpol; m_vpol[i] = vpol;
  endtask

  task automatic model_edge(input bit r, input bit t);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_p[i] = m_ht[i] * m_vt[i] - 1;
        m_ls[i] = 1'b0; m_fs[i] = 1'b0; m_fc[i] = 0;
      end else if (t) begin
        m_p[i] = (m_p[i] + 1) % (m_ht[i] * m_vt[i]);
        m_ls[i] = (m_p[i] % m_ht[i]) == 0;
        m_fs[i] = (m_p[i] == 0);
        if (m_fs[i]) m_fc[i] = (m_fc[i] + 1) % 65536;
      end else begin
        m_ls[i] = 1'b0; m_fs[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_one(input int i, input string sfx,
                             input logic [31:0] ox, input logic [31:0] oy,
                             input logic ode, input logic ohs, input logic ovs,
                             input logic ols, input logic ofs);
    int ex, ey;
    bit ede, ehs, evs;
    ex  = m_p[i] % m_ht[i];
    ey  = m_p[i] / m_ht[i];
    ede = (ex < m_hv[i]) && (ey < m_vv[i]);
    ehs = (ex >= m_hs0[i] && ex < m_hs1[i]) ? m_hpol[i] : !m_hpol[i];
    evs = (ey >= m_vs0[i] && ey < m_vs1[i]) ? m_vpol[i] : !m_vpol[i];
    check({"x_", sfx}, ox, ex);
    check({"y_", sfx}, oy, ey);
    check({"de_", sfx}, {31'd0, ode}, {31'd0, ede});
    check({"hsync_", sfx}, {31'd0, ohs}, {31'd0, ehs});
    check({"vsync_", sfx}, {31'd0, ovs}, {31'd0, evs});
    check({"line_start_", sfx}, {31'd0, ols}, {31'd0, m_ls[i]});
    check({"frame_start_", sfx}, {31'd0, ofs}, {31'd0, m_fs[i]});
  endtask

  // Drive one clk with the given inputs, then compare everything #1 after the edge.
  task automatic step(input bit r, input bit t);
    reset = r;
    pclk  = t;
    @(posedge clk);
    #1;
    model_edge(r, t);
    compare_one(0, "s", 32'(x_s), 32'(y_s), de_s, hs_s, vs_s, ls_s, fs_s);
    compare_one(1, "d", 32'(x_d), 32'(y_d), de_d, hs_d, vs_d, ls_d, fs_d);
`ifdef VGA_FRAME_CNT_EN
    check("frame_cnt_s", 32'(fc_s), m_fc[0]);
    check("frame_cnt_d", 32'(fc_d), m_fc[1]);
`endif
    if (r) begin
      f_seen = 1'b0;
      l_seen = 1'b0;
    end else if (t) begin
      if (fs_s) begin
        if (f_seen) begin
          check("frame_ticks_s", f_ticks, SHT * SVT);
          check("frame_de_ticks_s", f_de, SH_V * SV_V);
          check("frame_vsync_ticks_s", f_vs, SV_S * SHT);
        end
        f_seen = 1'b1; f_ticks = 0; f_de = 0; f_vs = 0;
      end
      f_ticks++;
      f_de += int'(de_s);
      f_vs += int'(!vs_s);
      if (ls_d) begin
        if (l_seen) begin
          check("line_ticks_d", l_ticks, 800);
          check("line_de_ticks_d", l_de, 640);
          check("line_hsync_ticks_d", l_hs, 96);
        end
        l_seen = 1'b1; l_ticks = 0; l_de = 0; l_hs = 0;
      end
      l_ticks++;
      l_de += int'(de_d);
      l_hs += int'(!hs_d);
    end
  endtask

  initial begin
    int mode;
    set_axis(0, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, 1'b1, 1'b0);
    set_axis(1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);

    // Reset for 10 clks while pclk keeps ticking every 4th clk.
    for (int i = 0; i < 10; i++) step(1'b1, (i % 4) == 3);
    check("rst_x", 32'(x_d), 799);
    check("rst_y", 32'(y_d), 524);
    check("rst_hsync", {31'd0, hs_d}, 1);
    check("rst_vsync", {31'd0, vs_d}, 1);
    check("rst_de", {31'd0, de_d}, 0);

    // First tick after release lands on (0,0) with both pulses for one clk.
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("first_frame_start", {31'd0, fs_d}, 1);
    check("first_line_start", {31'd0, ls_d}, 1);
    check("first_de", {31'd0, de_d}, 1);
    step(1'b0, 1'b0);
    check("first_frame_start_drop", {31'd0, fs_d}, 0);

    // Randomized tick patterns in 200-clk segments, with rare reset pulses.
    for (int seg = 0; seg < 60; seg++) begin
      mode = int'($urandom_range(0, 3));
      for (int c = 0; c < 200; c++) begin
        bit t;
        case (mode)
          0:       t = (c % 4) == 3;
          1:       t = 1'b1;
          2:       t = $urandom_range(0, 1) == 1;
          default: t = $urandom_range(0, 7) == 0;
        endcase
        step($urandom_range(0, 4999) == 0, t);
      end
    end

    // Freeze mid-line at x=300 on the default raster for 100 clks.
    for (int n = 0; n < 1000 && (m_p[1] % m_ht[1]) != 300; n++) step(1'b0, 1'b1);
    check("hold_reach_x", 32'(x_d), 300);
    for (int n = 0; n < 100; n++) step(1'b0, 1'b0);
    check("hold_x", 32'(x_d), 300);
    step(1'b0, 1'b1);
    check("hold_next_x", 32'(x_d), 301);

    // Reset coincident with a tick mid-frame on the small raster at (10,5).
    for (int n = 0; n < 400 && m_p[0] != 5 * SHT + 10; n++) step(1'b0, 1'b1);
    check("mid_reach", 32'(x_s) + 32'(y_s) * 100, 510);
    step(1'b1, 1'b1);
    check("mid_rst_x", 32'(x_s), SHT - 1);
    check("mid_rst_y", 32'(y_s), SVT - 1);
    check("mid_rst_hsync", {31'd0, hs_s}, 0);
    step(1'b0, 1'b1);
    check("mid_rst_frame_start", {31'd0, fs_s}, 1);
    check("mid_rst_xy", 32'(x_s) + 32'(y_s), 0);
    for (int n = 0; n < 300; n++) step(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
